// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: instruction class, opcodes,
// flag bit positions and controller states.
package alu_pkg;

    localparam logic [1:0] ALU_CLASS = 2'b00;

    typedef enum logic [3:0] {
        ADD_RR = 4'b0000,
        ADD_KA = 4'b0001,
        SUB_RR = 4'b0010,
        SUB_KA = 4'b0011,
        CMP_RR = 4'b0100,
        CMP_KA = 4'b0101,
        RLS    = 4'b0110,
        RRS    = 4'b0111,
        AND_RR = 4'b1000,
        AND_KA = 4'b1001,
        IOR_RR = 4'b1010,
        IOR_KA = 4'b1011,
        XOR_RR = 4'b1100,
        XOR_KA = 4'b1101,
        NOT_AB = 4'b1110,
        NOT_KA = 4'b1111
    } alu_op_e;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WB    = 2'd2
    } alu_state_e;

    // Odd opcodes take k and write A, except RRS which is a reg-reg shift.
    function automatic logic uses_imm(input alu_op_e op);
        return op[0] && (op != RRS);
    endfunction

    function automatic logic is_shift(input alu_op_e op);
        return (op == RLS) || (op == RRS);
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative logical shifter: loads an operand and amount, then moves one bit
// per cycle until the count is exhausted, remembering the last bit shifted out.
module alu_shift_unit #(
    parameter int DATA_W = 8,
    parameter int SHW    = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              dir_right,
    input  logic [SHW-1:0]    amount,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              last,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic              carry_q, carry_d;

    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        if (load) begin
            data_d  = din;
            cnt_d   = amount;
            carry_d = 1'b0;
        end else if (cnt_q != '0) begin
            if (dir_right) begin
                carry_d = data_q[0];
                data_d  = data_q >> 1;
            end else begin
                carry_d = data_q[DATA_W-1];
                data_d  = data_q << 1;
            end
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    assign busy      = (cnt_q != '0);
    // The step taken in this cycle is the final one.
    assign last      = (cnt_q == SHW'(1));
    assign result    = data_q;
    assign carry_out = carry_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential register-file ALU: accepts one instruction per handshake, runs
// shifts iteratively, writes back through a one-hot strobe and keeps Z/N/C/V.
//
// state    | meaning
// ST_IDLE  | in_ready high, waiting for an instruction
// ST_SHIFT | shifter stepping one bit per cycle
// ST_WB    | write-back strobe, done pulse, flags loaded at end of cycle
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [15:0]                    inst,
    input  logic [NREGS-1:0][DATA_W-1:0]   regs_oup,
    output logic [DATA_W-1:0]              regs_inp,
    output logic [NREGS-1:0]               regs_we,
    output logic [3:0]                     flags,
    output logic                           done,
    output logic                           err
);

    localparam int SHW = $clog2(DATA_W);
    localparam int MSB = DATA_W - 1;

    alu_state_e        state_q, state_d;
    alu_op_e           op_q, op_d;
    logic [1:0]        dst_q, dst_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic              err_q, err_d;
    logic [3:0]        flags_q, flags_d;

    logic              sh_load, sh_busy, sh_last, sh_carry;
    logic [DATA_W-1:0] sh_result;

    logic [DATA_W:0]   sum, diff;
    logic [DATA_W-1:0] res;
    logic              res_c, res_v, writes;

    alu_shift_unit #(.DATA_W(DATA_W), .SHW(SHW)) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .dir_right (op_d == RRS),
        .amount    (x_d[SHW-1:0]),
        .din       (a_d),
        .busy      (sh_busy),
        .last      (sh_last),
        .result    (sh_result),
        .carry_out (sh_carry)
    );

    assign sum  = {1'b0, a_q} + {1'b0, x_q};
    assign diff = {1'b0, x_q} - {1'b0, a_q};

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op_q)
            ADD_RR, ADD_KA: begin
                res   = sum[MSB:0];
                res_c = sum[DATA_W];
                res_v = (a_q[MSB] == x_q[MSB]) && (res[MSB] != a_q[MSB]);
            end
            SUB_RR, SUB_KA, CMP_RR, CMP_KA: begin
                res   = diff[MSB:0];
                res_c = diff[DATA_W];
                res_v = (x_q[MSB] != a_q[MSB]) && (res[MSB] != x_q[MSB]);
            end
            RLS, RRS: begin
                res   = sh_result;
                res_c = sh_carry;
            end
            AND_RR, AND_KA: res = a_q & x_q;
            IOR_RR, IOR_KA: res = a_q | x_q;
            XOR_RR, XOR_KA: res = a_q ^ x_q;
            NOT_AB:         res = ~a_q;
            NOT_KA:         res = ~x_q;
            default:        res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        a_d     = a_q;
        x_d     = x_q;
        err_d   = err_q;
        flags_d = flags_q;
        sh_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d  = alu_op_e'(inst[13:10]);
                    dst_d = uses_imm(op_d) ? inst[9:8] : inst[7:6];
                    a_d   = regs_oup[inst[9:8]];
                    x_d   = uses_imm(op_d) ? DATA_W'(inst[7:0]) : regs_oup[inst[7:6]];
                    err_d = (inst[15:14] != ALU_CLASS);
                    // Amount 0 shifts skip SHIFT; the loaded operand is the result.
                    if (!err_d && is_shift(op_d)) begin
                        sh_load = 1'b1;
                        state_d = (x_d[SHW-1:0] != '0) ? ST_SHIFT : ST_WB;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_SHIFT: begin
                if (sh_last) state_d = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
                if (!err_q) begin
                    flags_d[FLG_Z] = (res == '0);
                    flags_d[FLG_N] = res[MSB];
                    flags_d[FLG_C] = res_c;
                    flags_d[FLG_V] = res_v;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= ADD_RR;
            dst_q   <= '0;
            a_q     <= '0;
            x_q     <= '0;
            err_q   <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            a_q     <= a_d;
            x_q     <= x_d;
            err_q   <= err_d;
            flags_q <= flags_d;
        end
    end

    assign writes   = !err_q && (op_q != CMP_RR) && (op_q != CMP_KA);
    assign in_ready = (state_q == ST_IDLE);
    assign done     = (state_q == ST_WB);
    assign err      = (state_q == ST_WB) && err_q;
    assign regs_we  = (done && writes) ? (NREGS'(1) << dst_q) : '0;
    assign regs_inp = (done && !err_q) ? res : '0;
    assign flags    = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: table of hand-computed vectors plus sequences
// for back-to-back issue and reset during a long shift.
module tb_alu_seq;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      inst = 16'h0000;
    logic [3:0][7:0]  regs_oup = '0;
    logic [7:0]       regs_inp;
    logic [3:0]       regs_we;
    logic [3:0]       flags;
    logic             done;
    logic             err;

    int checks = 0;
    int errors = 0;

    alu_seq #(.DATA_W(8), .NREGS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inst     (inst),
        .regs_oup (regs_oup),
        .regs_inp (regs_inp),
        .regs_we  (regs_we),
        .flags    (flags),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  r0, r1, r2, r3;
        logic [15:0] inst;
        int          lat;
        logic [3:0]  we;
        logic [7:0]  inp;
        logic        err;
        logic [3:0]  flg;   // {Z,N,C,V} after completion
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [7:0] r0, input logic [7:0] r1,
                                    input logic [7:0] r2, input logic [7:0] r3,
                                    input logic [15:0] ins, input int lat,
                                    input logic [3:0] we, input logic [7:0] inp,
                                    input logic er, input logic [3:0] flg);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.r2 = r2; v.r3 = r3;
        v.inst = ins; v.lat = lat; v.we = we; v.inp = inp; v.err = er; v.flg = flg;
        vecs.push_back(v);
    endfunction

    // Issue one instruction and follow it to completion; register contents are
    // inverted right after accept so any late re-read shows up in the result.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        logic got;
        regs_oup = {v.r3, v.r2, v.r1, v.r0};
        inst     = v.inst;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        regs_oup = ~regs_oup;
        cyc = 1;
        got = 1'b0;
        while (cyc <= 20 && !got) begin
            if (done) begin
                got = 1'b1;
            end else begin
                check($sformatf("v%0d_we_busy", idx), {28'd0, regs_we}, 32'd0);
                check($sformatf("v%0d_ready_busy", idx), {31'd0, in_ready}, 32'd0);
                @(posedge clk); #1;
                cyc++;
            end
        end
        check($sformatf("v%0d_done_seen", idx), {31'd0, got}, 32'd1);
        if (got) begin
            check($sformatf("v%0d_latency", idx), cyc, v.lat);
            check($sformatf("v%0d_we", idx), {28'd0, regs_we}, {28'd0, v.we});
            if (v.we != 4'd0)
                check($sformatf("v%0d_inp", idx), {24'd0, regs_inp}, {24'd0, v.inp});
            check($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.err});
            check($sformatf("v%0d_ready_wb", idx), {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", idx), {31'd0, done}, 32'd0);
            check($sformatf("v%0d_flags", idx), {28'd0, flags}, {28'd0, v.flg});
            check($sformatf("v%0d_ready_after", idx), {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        //       r0     r1     r2     r3     inst      lat we     inp    err  flags
        add_vec(8'h7F, 8'h01, 8'h00, 8'h00, 16'h0040, 1, 4'b0010, 8'h80, 1'b0, 4'b0101); // ADD R0,R1
        add_vec(8'h00, 8'h00, 8'h05, 8'h00, 16'h0E03, 1, 4'b0100, 8'hFE, 1'b0, 4'b0110); // SUB k,R2
        add_vec(8'h00, 8'h00, 8'h00, 8'h10, 16'h1710, 1, 4'b0000, 8'h00, 1'b0, 4'b1000); // CMP k,R3
        add_vec(8'h00, 8'h00, 8'h00, 8'h00, 16'h8000, 1, 4'b0000, 8'h00, 1'b1, 4'b1000); // non-ALU
        add_vec(8'h81, 8'h03, 8'h00, 8'h00, 16'h1840, 4, 4'b0010, 8'h08, 1'b0, 4'b0000); // RLS by 3
        add_vec(8'h00, 8'h00, 8'h81, 8'h01, 16'h1EC0, 2, 4'b1000, 8'h40, 1'b0, 4'b0010); // RRS by 1
        add_vec(8'h81, 8'h08, 8'h00, 8'h00, 16'h1840, 1, 4'b0010, 8'h81, 1'b0, 4'b0100); // RLS by 0
        add_vec(8'h00, 8'h01, 8'h00, 8'h00, 16'h05FF, 1, 4'b0010, 8'h00, 1'b0, 4'b1010); // ADD k,R1 carry
        add_vec(8'h01, 8'h80, 8'h00, 8'h00, 16'h0840, 1, 4'b0010, 8'h7F, 1'b0, 4'b0001); // SUB R0,R1 ovf
        add_vec(8'h00, 8'h00, 8'h00, 8'hF0, 16'h270F, 1, 4'b1000, 8'h00, 1'b0, 4'b1000); // AND k,R3
        add_vec(8'hA0, 8'h00, 8'h0F, 8'h00, 16'h2A00, 1, 4'b0001, 8'hAF, 1'b0, 4'b0100); // IOR R2,R0
        add_vec(8'h00, 8'hFF, 8'h0F, 8'h00, 16'h3180, 1, 4'b0100, 8'hF0, 1'b0, 4'b0100); // XOR R1,R2
        add_vec(8'h55, 8'h00, 8'h00, 8'h00, 16'h38C0, 1, 4'b1000, 8'hAA, 1'b0, 4'b0100); // NOT R0,R3
        add_vec(8'h00, 8'h00, 8'h33, 8'h00, 16'h3EFF, 1, 4'b0100, 8'h00, 1'b0, 4'b1000); // NOT k,R2
        add_vec(8'h00, 8'h00, 8'h00, 8'h00, 16'hC000, 1, 4'b0000, 8'h00, 1'b1, 4'b1000); // class 11
        add_vec(8'h00, 8'h00, 8'h81, 8'h07, 16'h1EC0, 8, 4'b1000, 8'h01, 1'b0, 4'b0000); // RRS by 7
        add_vec(8'h80, 8'h7F, 8'h00, 8'h00, 16'h1040, 1, 4'b0000, 8'h00, 1'b0, 4'b0111); // CMP R0,R1

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_we",    {28'd0, regs_we},  32'd0);
        check("rst_inp",   {24'd0, regs_inp}, 32'd0);
        check("rst_flags", {28'd0, flags},    32'd0);
        check("rst_done",  {31'd0, done},     32'd0);
        check("rst_err",   {31'd0, err},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset in the middle of a 7-step shift; flags are 0111 going in.
        regs_oup = {8'h00, 8'h00, 8'h07, 8'h81};
        inst     = 16'h1840;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rmid_ready_c1", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("rmid_we_c2", {28'd0, regs_we}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rmid_ready_low", {31'd0, in_ready}, 32'd1);
        check("rmid_flags_low", {28'd0, flags},    32'd0);
        check("rmid_done_low",  {31'd0, done},     32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rmid_we_low",    {28'd0, regs_we},  32'd0);
            check("rmid_ready_low", {31'd0, in_ready}, 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("rmid_we_after",    {28'd0, regs_we},  32'd0);
            check("rmid_done_after",  {31'd0, done},     32'd0);
            check("rmid_ready_after", {31'd0, in_ready}, 32'd1);
        end
        run_vec(vecs[0], 100);

        // Back-to-back: in_valid held, second accept in the IDLE cycle after WB.
        regs_oup = {8'h00, 8'h00, 8'h01, 8'h01};
        inst     = 16'h0040;
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_done_c1", {31'd0, done},     32'd1);
        check("b2b_inp_c1",  {24'd0, regs_inp}, 32'h02);
        check("b2b_ready_c1", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("b2b_done_c2",  {31'd0, done},     32'd0);
        check("b2b_ready_c2", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("b2b_done_c3", {31'd0, done},    32'd1);
        check("b2b_we_c3",   {28'd0, regs_we}, 32'b0010);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_done_c4",  {31'd0, done},     32'd0);
        check("b2b_flags_c4", {28'd0, flags},    32'd0);
        @(posedge clk); #1;
        check("b2b_done_c5",  {31'd0, done},     32'd0);
        check("b2b_ready_c5", {31'd0, in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, parametrised successor to the combinational register-file ALU. It accepts one 16-bit ALU-class instruction per valid/ready handshake and reads operands from the register file outputs. It computes the result and writes it back through a registered one-hot write strobe, then updates a persistent Z/N/C/V flag register. Shifts are by a variable amount and execute iteratively, one bit per cycle; all other ops take one execute cycle.

## Interface
Parameters:
- `DATA_W`, default 8: register and datapath width; must be a power of two and ≥ 8.
- `NREGS`, default 4: register count; fixed at 4 by the 2-bit register fields.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `inst` is valid.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `inst`  in  16  instruction; sampled on accept.
- `regs_oup`  in  NREGS×DATA_W  register file read data; sampled on accept.
- `regs_inp`  out  DATA_W  write-back data; one shared bus, no tristate.
- `regs_we`  out  NREGS  one-hot write strobe; one cycle wide.
- `flags`  out  4  {Z,N,C,V}, registered.
- `done`  out  1  one-cycle pulse at instruction completion.
- `err`  out  1  one-cycle pulse with `done` for a non-ALU instruction.

## Operation
Instruction fields:
- class `inst[15:14]`; 00 is ALU.
- op `inst[13:10]`.
- A `inst[9:8]`, B `inst[7:6]`.
- k `inst[7:0]`, zero-extended to DATA_W.

Reg-reg forms (even op) write B. Immediate forms (odd op) write A. In the ops below, "x" denotes B for reg-reg forms and k for immediate forms.

Ops:
- 0000/0001 ADD: res = A + x.
- 0010/0011 SUB: res = x − A.
- 0100/0101 CMP: computes x − A; updates flags only, never writes.
- 0110 RLS A,B: B = A << B[log2(DATA_W)−1:0], logical.
- 0111 RRS A,B: B = A >> amount, logical.
- 1000/1001 AND, 1010/1011 IOR, 1100/1101 XOR: bitwise, res = A op x.
- 1110 NOT A,B: B = ~A.
- 1111 NOT k,A: A = ~k.

Flags:
- Z = (res == 0); N = res[DATA_W−1].
- ADD: C = carry-out; V = signed overflow.
- SUB/CMP: C = borrow (x < A unsigned); V = signed overflow of x − A.
- Shifts: C = last bit shifted out; C = 0 for amount 0. V = 0.
- Logic/NOT: C = 0, V = 0.

States:
- IDLE: accept on in_valid & in_ready. Latch the op, destination, and both operands. Go to SHIFT if the op is a shift with amount > 0; otherwise go to WB.
- SHIFT: shift one bit per cycle and decrement the counter. Go to WB when the counter reaches 0.
- WB:
  - Drive regs_inp = res and regs_we = one-hot(dst); CMP and err drive regs_we = 0.
  - Pulse `done`.
  - Load flags at the end of the cycle; flags are not changed on err.
  - Return to IDLE.
- Non-ALU class: accepted and sent straight to WB with err = 1, no write, flags unchanged.
- Back-to-back: when in_valid is held high, the next instruction is accepted in the IDLE cycle after WB.

## Timing
- Reset values: in_ready = 1 (IDLE); regs_we = 0, regs_inp = 0, flags = 0, done = 0, err = 0.
- Latency, with the accept edge as cycle 0:
  - Non-shift op: WB in cycle 1.
  - Shift by n: WB in cycle 1 + n.
- Flags are visible in the cycle after `done`.
- Minimum issue interval is 2 cycles.
- regs_oup is not re-read after accept. A register change during SHIFT does not affect the result.
- Reset asserted mid-operation: immediate abort, no write, flags cleared, in_ready = 1 while rst_n is low and after release.
- in_valid while in_ready = 0 is ignored; the source holds inst.

## Structure
- `alu_pkg` holds the shared definitions:
  - class constant `ALU_CLASS = 2'b00`;
  - opcode enum `alu_op_e` (ADD_RR … NOT_KA);
  - flag bit indices `FLG_Z/N/C/V`;
  - state enum `alu_state_e`.
- One sub-module, `alu_shift_unit`: iterative shifter with load, direction, amount, busy, result and carry-out.

## Test plan
- R0=0x7F, R1=0x01, inst 0x0040 (ADD R0,R1) -> cycle 1: regs_we=0010, regs_inp=0x80, done=1; then flags Z=0 N=1 C=0 V=1.
- R2=0x05, inst 0x0E03 (SUB k=0x03,R2) -> regs_we=0100, regs_inp=0xFE; flags N=1 C=1 Z=0 V=0.
- R3=0x10, inst 0x1710 (CMP k=0x10,R3) -> done pulse, regs_we=0000 in all cycles; flags Z=1 C=0.
- R0=0x81, R1=0x03, inst 0x1840 (RLS R0,R1) -> in_ready low cycles 1–4; WB at cycle 4: regs_we=0010, regs_inp=0x08, C=0.
- inst 0x8000 -> cycle 1: done=1, err=1, regs_we=0; flags unchanged.
- RLS with amount 7, rst_n low at cycle 3 -> regs_we never asserted, flags=0, in_ready=1 after release; next ADD completes normally.
